// File: rtl/control_unit_pkg.sv
// Shared types, opcode/funct constants and per-instruction control words for the control unit.
package control_signals;

   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned CTRL_W   = 11;

   typedef enum logic [1:0] {WA_RT = 2'b00, WA_RD = 2'b01, WA_R31 = 2'b10} sel_wa_t;
   typedef enum logic [1:0] {RES_ALU = 2'b00, RES_DMEM = 2'b01, RES_PC4 = 2'b10} sel_result_t;
   typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11} sel_pc_t;
   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_RSVD = 2'b11} alu_op_t;

   // MSB to LSB: rf_we, sel_wa, sel_alu_b, dmem_we, sel_result, sel_pc, alu_op
   typedef struct packed {
      logic        rf_we;
      sel_wa_t     sel_wa;
      logic        sel_alu_b;
      logic        dmem_we;
      sel_result_t sel_result;
      sel_pc_t     sel_pc;
      alu_op_t     alu_op;
   } control_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
   localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
   localparam logic [OPCODE_W-1:0] OP_NOP   = 6'h3F;
   localparam logic [FUNCT_W-1:0]  FUNCT_JR = 6'h08;

   localparam control_t LWc    = control_t'(11'b1_00_1_0_01_00_00);
   localparam control_t SWc    = control_t'(11'b0_00_1_1_00_00_00);
   localparam control_t ADDIc  = control_t'(11'b1_00_1_0_00_00_00);
   localparam control_t Jc     = control_t'(11'b0_00_0_0_00_10_00);
   localparam control_t JALc   = control_t'(11'b1_10_0_0_10_10_00);
   localparam control_t BEQNc  = control_t'(11'b0_00_0_0_00_00_01);
   localparam control_t BEQYc  = control_t'(11'b0_00_0_0_00_01_01);
   localparam control_t RTYPEc = control_t'(11'b1_01_0_0_00_00_10);
   localparam control_t JRc    = control_t'(11'b0_00_0_0_00_11_00);
   localparam control_t NOPc   = control_t'(11'b0_00_0_0_00_00_00);

endpackage

// File: rtl/control_unit_if.sv
// Control word carried as individual fields, driven by the control unit and read by the datapath.
interface ControlBus;
   import control_signals::*;

   logic        rf_we;
   sel_wa_t     sel_wa;
   logic        sel_alu_b;
   logic        dmem_we;
   sel_result_t sel_result;
   sel_pc_t     sel_pc;
   alu_op_t     alu_op;

   modport driver   (output rf_we, sel_wa, sel_alu_b, dmem_we, sel_result, sel_pc, alu_op);
   modport receiver (input  rf_we, sel_wa, sel_alu_b, dmem_we, sel_result, sel_pc, alu_op);
endinterface

// File: rtl/control_unit_main_decoder.sv
// Zero-independent opcode/funct decode; BEQ is emitted as not-taken and flagged for branch resolution.
module main_decoder
   import control_signals::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNCT_W-1:0]  funct,
   output control_t            ctrl_c,
   output logic                branch_c,
   output logic                illegal_c
);

   always_comb begin
      ctrl_c    = NOPc;
      branch_c  = 1'b0;
      illegal_c = 1'b0;
      case (opcode)
         OP_RTYPE: ctrl_c = (funct == FUNCT_JR) ? JRc : RTYPEc;
         OP_J:     ctrl_c = Jc;
         OP_JAL:   ctrl_c = JALc;
         OP_BEQ: begin
            ctrl_c   = BEQNc;
            branch_c = 1'b1;
         end
         OP_ADDI:  ctrl_c = ADDIc;
         OP_LW:    ctrl_c = LWc;
         OP_SW:    ctrl_c = SWc;
         OP_NOP:   ctrl_c = NOPc;
         default:  illegal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Instruction control unit: decode, BEQ resolution on zero, sticky illegal_op flag.
// Define CONTROL_UNIT_REG_OUT_EN to register control_bus (one cycle of latency).
module control_unit
   import control_signals::*;
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                zero,
   ControlBus.driver           control_bus,
   output logic                illegal_op
);

   control_t   dec_ctrl;
   control_t   ctrl_next;
   control_t   ctrl_out;
   logic       is_branch;
   logic       is_illegal;
   logic [1:0] rst_sync;
   logic       rst_int_n;

   main_decoder u_main_decoder (
      .opcode    (opcode),
      .funct     (funct),
      .ctrl_c    (dec_ctrl),
      .branch_c  (is_branch),
      .illegal_c (is_illegal)
   );

   // Reset asserts asynchronously, releases on a clock edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   always_comb begin
      ctrl_next = dec_ctrl;
      if (is_branch && zero) ctrl_next.sel_pc = PC_BRANCH;
   end

   always_ff @(posedge clock or negedge rst_int_n) begin
      if (!rst_int_n)      illegal_op <= 1'b0;
      else if (is_illegal) illegal_op <= 1'b1;
   end

`ifdef CONTROL_UNIT_REG_OUT_EN
   control_t ctrl_q;

   always_ff @(posedge clock or negedge rst_int_n) begin
      if (!rst_int_n) ctrl_q <= NOPc;
      else            ctrl_q <= ctrl_next;
   end
   assign ctrl_out = ctrl_q;
`else
   assign ctrl_out = ctrl_next;
`endif

   assign control_bus.rf_we      = ctrl_out.rf_we;
   assign control_bus.sel_wa     = ctrl_out.sel_wa;
   assign control_bus.sel_alu_b  = ctrl_out.sel_alu_b;
   assign control_bus.dmem_we    = ctrl_out.dmem_we;
   assign control_bus.sel_result = ctrl_out.sel_result;
   assign control_bus.sel_pc     = ctrl_out.sel_pc;
   assign control_bus.alu_op     = ctrl_out.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; follows CONTROL_UNIT_REG_OUT_EN if defined.
module tb_control_unit;

   logic        clock;
   logic        reset_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        illegal_op;
   logic [10:0] word;
   int          checks;
   int          errors;

   ControlBus cb ();

   control_unit dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .control_bus (cb),
      .illegal_op  (illegal_op)
   );

   assign word = {cb.rf_we, cb.sel_wa, cb.sel_alu_b, cb.dmem_we, cb.sel_result, cb.sel_pc, cb.alu_op};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Apply inputs and wait until the resulting word is visible on the bus
   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z);
      opcode = op;
      funct  = fn;
      zero   = z;
`ifdef CONTROL_UNIT_REG_OUT_EN
      @(posedge clock);
`endif
      #1;
   endtask

   typedef struct {
      string       tag;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      opcode  = 6'h3F;
      funct   = 6'h00;
      zero    = 1'b0;

      vecs.push_back('{"lw",          6'h23, 6'h00, 1'b0, 11'b10010010000});
      vecs.push_back('{"sw",          6'h2B, 6'h00, 1'b0, 11'b00011000000});
      vecs.push_back('{"addi",        6'h08, 6'h00, 1'b0, 11'b10010000000});
      vecs.push_back('{"j",           6'h02, 6'h00, 1'b0, 11'b00000001000});
      vecs.push_back('{"jal",         6'h03, 6'h00, 1'b0, 11'b11000101000});
      vecs.push_back('{"beq_nt",      6'h04, 6'h00, 1'b0, 11'b00000000001});
      vecs.push_back('{"beq_t",       6'h04, 6'h00, 1'b1, 11'b00000000101});
      vecs.push_back('{"rtype_add",   6'h00, 6'h20, 1'b0, 11'b10100000010});
      vecs.push_back('{"jr",          6'h00, 6'h08, 1'b0, 11'b00000001100});
      vecs.push_back('{"rtype_z1",    6'h00, 6'h22, 1'b1, 11'b10100000010});
      vecs.push_back('{"lw_funct",    6'h23, 6'h3F, 1'b0, 11'b10010010000});
      vecs.push_back('{"j_zero",      6'h02, 6'h08, 1'b1, 11'b00000001000});
      vecs.push_back('{"jal_funct",   6'h03, 6'h2A, 1'b1, 11'b11000101000});
      vecs.push_back('{"sw_zero",     6'h2B, 6'h11, 1'b1, 11'b00011000000});
      vecs.push_back('{"nop",         6'h3F, 6'h00, 1'b0, 11'b00000000000});

      #3;
      check("rst_illegal", 11'(illegal_op), 11'b0);
`ifdef CONTROL_UNIT_REG_OUT_EN
      check("rst_word", word, 11'b0);
`endif
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].fn, vecs[i].z);
         check(vecs[i].tag, word, vecs[i].exp);
      end

      @(posedge clock);
      #1;
      check("nop_not_illegal", 11'(illegal_op), 11'b0);

`ifdef CONTROL_UNIT_REG_OUT_EN
      drive(6'h2B, 6'h00, 1'b0);
      opcode = 6'h23;
      #1;
      check("reg_hold", word, 11'b00011000000);
      @(posedge clock);
      #1;
      check("reg_update", word, 11'b10010010000);
`endif

      drive(6'h3E, 6'h00, 1'b0);
      check("illegal_word", word, 11'b0);
`ifndef CONTROL_UNIT_REG_OUT_EN
      check("illegal_pre_edge", 11'(illegal_op), 11'b0);
`endif
      @(posedge clock);
      #1;
      check("illegal_set", 11'(illegal_op), 11'b1);

      drive(6'h23, 6'h00, 1'b0);
      check("illegal_sticky", 11'(illegal_op), 11'b1);
      check("lw_after_illegal", word, 11'b10010010000);
      @(posedge clock);
      #1;
      check("illegal_sticky2", 11'(illegal_op), 11'b1);

      // Mid-cycle reset: must clear without a clock edge
      #3;
      reset_n = 1'b0;
      #1;
      check("async_clear", 11'(illegal_op), 11'b0);
`ifdef CONTROL_UNIT_REG_OUT_EN
      check("reg_rst_word", word, 11'b0);
`else
      check("word_in_reset", word, 11'b10010010000);
`endif
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("post_rst_illegal", 11'(illegal_op), 11'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
